fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction fetch controller between the 16-bit core and byte-wide program memory.
//  - Takes a fetch address from the core.
//  - Runs two byte reads (low byte at pc, high byte at pc+1) over a req/ack memory handshake.
//  - Assembles the 16-bit instruction and holds it under a valid/ready handshake until the core consumes it.
//  - Supports flush on branch and a memory-timeout error.
// PARAMETERS
//  ADDR_W    16  width of pc and mem_addr
//  MAX_WAIT  15  cycles a byte request may wait for mem_ack before timeout (1..255)
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst          in   1       asynchronous, active-low reset
//  pc           in   ADDR_W  fetch address, sampled when pc_valid accepted
//  pc_valid     in   1       core requests a fetch of pc
//  pc_ready     out  1       fetch address accepted this cycle (pc_valid & pc_ready)
//  flush        in   1       abandon current fetch/held instruction (branch redirect)
//  inst         out  16      assembled instruction {hi_byte, lo_byte}
//  inst_valid   out  1       inst is valid and stable
//  inst_ready   in   1       core consumes inst this cycle
//  mem_addr     out  ADDR_W  program-memory byte address
//  mem_req      out  1       byte read request
//  mem_ack      in   1       mem_rdata valid this cycle; completes the request
//  mem_rdata    in   8       read byte
//  busy         out  1       state != IDLE
//  timeout      out  1       sticky: a request exceeded MAX_WAIT
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, mem_req=0, mem_addr=0, inst=0, inst_valid=0, pc_ready=0,
//   timeout=0, wait counter=0. All outputs are registered except pc_ready = (state==IDLE) & ~timeout.
//  States:
//   IDLE -> REQ_LO when pc_valid & pc_ready & ~flush. pc is latched, mem_addr=pc, mem_req=1.
//   REQ_LO: mem_ack sampled 1 -> lo_byte<=mem_rdata, mem_addr<=pc+1, go to REQ_HI.
//    mem_req stays 1 across the transition, so the next request is back-to-back.
//   REQ_HI: mem_ack sampled 1 -> inst<={mem_rdata,lo_byte}, mem_req<=0, inst_valid<=1, go to HOLD.
//   HOLD: inst and inst_valid are held stable until inst_ready=1. On that edge inst_valid<=0 and
//    the state returns to IDLE. No overlap: a new pc is accepted no earlier than the following cycle.
//   ERR: mem_req=0, timeout=1. Leave to IDLE only on flush; timeout clears on that same edge.
//  Address arithmetic: pc+1 is modulo 2^ADDR_W (pc=all-ones -> hi byte read from address 0).
//   pc need not be even.
//  Memory handshake:
//   - mem_addr is stable while mem_req=1 and a byte is outstanding.
//   - mem_ack is ignored when mem_req=0 or in IDLE/HOLD/ERR.
//   - Ack may be combinational with req (zero wait).
//  Timeout: the wait counter clears on every new byte request and increments each REQ cycle
//   without ack. Counter reaching MAX_WAIT with no ack in that cycle -> ERR.
//  Flush (highest priority, any state):
//   - Next edge: IDLE, mem_req=0, inst_valid=0, counter=0, timeout=0.
//   - A same-cycle mem_ack, inst_ready or pc_valid is discarded.
//   - Abandoned requests: memory must drop them when mem_req falls.
//  Minimum latency (zero-wait memory): pc accepted at edge N; mem_req high after N;
//   lo captured at N+1; hi captured and inst_valid=1 after N+2.
//  Reset mid-operation: immediate return to reset values; no partial inst is ever presented.
// TESTING
//  1 Zero-wait memory returns 0x40 at 0x0000 and 0x4A at 0x0001; pc=0x0000 accepted
//    -> inst=0x4A40, inst_valid 2 cycles after mem_req rises, mem_addr sequence 0,1.
//  2 Ack delayed 3 cycles per byte, inst_ready held low 4 cycles
//    -> inst stays 0x4A40 and inst_valid stays 1 until ready; pc_ready=0 throughout.
//  3 pc=0xFFFF, memory returns 0x58 at 0xFFFF and 0x0A at 0x0000 -> mem_addr 0xFFFF then 0x0000, inst=0x0A58.
//  4 mem_ack never asserted, MAX_WAIT=15 -> timeout=1 and mem_req=0 after the 15th wait cycle;
//    pc_valid refused; flush -> IDLE with timeout=0.
//  5 flush in REQ_HI cycle with coincident mem_ack -> inst_valid never rises, mem_req=0 next cycle;
//    next pc=0x0004 fetches 0x5601 correctly.
//  6 rst pulsed low during REQ_LO -> all outputs at reset values immediately; recovery fetch of
//    pc=0x0002 gives inst=0x0A58.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: two byte reads over a req/ack memory port,
// assembled into a 16-bit instruction presented under a valid/ready handshake.
module fetch_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              timeout
);

  typedef enum logic [2:0] {IDLE, REQ_LO, REQ_HI, HOLD, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_nxt;
  logic [15:0]       inst_nxt;
  logic              ivld_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              tmo_nxt;
  logic [7:0]        lo_byte, lo_nxt;
  logic              take;
  logic              ack;

  // pc_ready is forced low while reset is held so nothing is offered mid-reset.
  assign pc_ready = rst & (state == IDLE) & ~timeout;
  assign take     = pc_valid & pc_ready & ~flush;
  assign ack      = mem_req & mem_ack;

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    req_nxt   = mem_req;
    inst_nxt  = inst;
    ivld_nxt  = inst_valid;
    cnt_nxt   = cnt;
    tmo_nxt   = timeout;
    lo_nxt    = lo_byte;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = REQ_LO;
          addr_nxt  = pc;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
        end
      end
      REQ_LO: begin
        if (ack) begin
          lo_nxt    = mem_rdata;
          addr_nxt  = mem_addr + ADDR_W'(1);
          state_nxt = REQ_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt == WAIT_LAST) begin
            state_nxt = ERR;
            req_nxt   = 1'b0;
            tmo_nxt   = 1'b1;
          end
        end
      end
      REQ_HI: begin
        if (ack) begin
          inst_nxt  = {mem_rdata, lo_byte};
          req_nxt   = 1'b0;
          ivld_nxt  = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt == WAIT_LAST) begin
            state_nxt = ERR;
            req_nxt   = 1'b0;
            tmo_nxt   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          ivld_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        req_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    // Branch redirect overrides everything, including a same-cycle ack.
    if (flush) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
      ivld_nxt  = 1'b0;
      cnt_nxt   = '0;
      tmo_nxt   = 1'b0;
      inst_nxt  = inst;
      lo_nxt    = lo_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
      cnt        <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_addr   <= addr_nxt;
      mem_req    <= req_nxt;
      inst       <= inst_nxt;
      inst_valid <= ivld_nxt;
      cnt        <= cnt_nxt;
      timeout    <= tmo_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Low byte is pure datapath; it is only read after being captured.
  always_ff @(posedge clk) begin
    lo_byte <= lo_nxt;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: byte-memory responder with
// programmable wait states and a fetch-level reference model.
module tb_fetch_sequencer;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        timeout;

  logic [7:0]  mem [0:65535];
  bit          mem_en = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Memory acks after ack_delay wait cycles of an outstanding request.
  assign mem_ack   = mem_req && mem_en && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch; expected word is {mem[pc+1], mem[pc]} with wrap.
  task automatic do_fetch(input string nm, input logic [15:0] pcv, input int d, input int hold);
    logic [15:0] pc1, expv, prev_addr;
    logic [15:0] seen[$];
    int          cyc;
    bit          prev_wait;
    pc1 = pcv + 16'd1;
    expv = {mem[pc1], mem[pcv]};
    ack_delay = d;
    mem_en = 1'b1;
    n_cmp++;
    if (pc_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s pc_ready_idle: got %b want 1", nm, pc_ready);
    end
    pc = pcv; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; pc = 16'($urandom);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== pcv) begin
      n_bad++; $display("FAIL %s first_req: got req=%b addr=%h want req=1 addr=%h", nm, mem_req, mem_addr, pcv);
    end
    cyc = 0; prev_wait = 1'b0; prev_addr = '0;
    while (inst_valid !== 1'b1 && cyc < 200) begin
      n_cmp++;
      if (pc_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL %s busy_wait: got pc_ready=%b busy=%b want 0/1", nm, pc_ready, busy);
      end
      if (prev_wait) begin
        n_cmp++;
        if (mem_addr !== prev_addr) begin
          n_bad++; $display("FAIL %s addr_stable: got %h want %h", nm, mem_addr, prev_addr);
        end
      end
      if (mem_req && mem_ack) seen.push_back(mem_addr);
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc !== 2 + 2 * d) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, 2 + 2 * d);
    end
    n_cmp++;
    if (inst !== expv) begin
      n_bad++; $display("FAIL %s inst: got %h want %h", nm, inst, expv);
    end
    n_cmp++;
    if (seen.size() != 2 || seen[0] !== pcv || seen[1] !== pc1) begin
      n_bad++; $display("FAIL %s addr_seq: got n=%0d first=%h want n=2 %h,%h", nm, seen.size(),
                        (seen.size() > 0) ? seen[0] : 16'hxxxx, pcv, pc1);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++; $display("FAIL %s req_drop: got %b want 0", nm, mem_req);
    end
    for (int i = 0; i < hold; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== expv || pc_ready !== 1'b0) begin
        n_bad++; $display("FAIL %s hold: got v=%b inst=%h rdy=%b want 1 %h 0", nm, inst_valid, inst, pc_ready, expv);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || pc_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s consume: got v=%b busy=%b rdy=%b want 0 0 1", nm, inst_valid, busy, pc_ready);
    end
  endtask

  task automatic test_reset();
    pc_valid = 1'b1;
    #3;
    n_cmp++;
    if ({mem_req, inst_valid, pc_ready, busy, timeout} !== 5'b0 || mem_addr !== 16'h0 || inst !== 16'h0) begin
      n_bad++; $display("FAIL reset_state: got req=%b v=%b rdy=%b busy=%b tmo=%b addr=%h inst=%h want zeros",
                        mem_req, inst_valid, pc_ready, busy, timeout, mem_addr, inst);
    end
    pc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (pc_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", pc_ready, busy);
    end
  endtask

  task automatic test_zero_wait();
    mem[16'h0000] = 8'h40; mem[16'h0001] = 8'h4A;
    do_fetch("zero_wait", 16'h0000, 0, 0);
    n_cmp++;
    if (inst !== 16'h4A40) begin
      n_bad++; $display("FAIL zero_wait_const: got %h want 4a40", inst);
    end
  endtask

  task automatic test_stall();
    do_fetch("stall", 16'h0000, 3, 4);
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h58; mem[16'h0000] = 8'h0A;
    do_fetch("wrap", 16'hFFFF, 1, 1);
    n_cmp++;
    if (inst !== 16'h0A58) begin
      n_bad++; $display("FAIL wrap_const: got %h want 0a58", inst);
    end
  endtask

  task automatic test_timeout();
    mem_en = 1'b0;
    pc = 16'h0100; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    repeat (MAX_WAIT - 1) tick();
    n_cmp++;
    if (timeout !== 1'b0 || mem_req !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: got tmo=%b req=%b want 0 1", timeout, mem_req);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1 || pc_ready !== 1'b0) begin
      n_bad++; $display("FAIL timeout_hit: got tmo=%b req=%b busy=%b rdy=%b want 1 0 1 0", timeout, mem_req, busy, pc_ready);
    end
    pc_valid = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (timeout !== 1'b1 || mem_req !== 1'b0 || pc_ready !== 1'b0) begin
      n_bad++; $display("FAIL timeout_refuse: got tmo=%b req=%b rdy=%b want 1 0 0", timeout, mem_req, pc_ready);
    end
    pc_valid = 1'b0;
    mem_en = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (timeout !== 1'b0 || busy !== 1'b0 || pc_ready !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL timeout_flush: got tmo=%b busy=%b rdy=%b req=%b want 0 0 1 0", timeout, busy, pc_ready, mem_req);
    end
    mem[16'h0100] = 8'h3C; mem[16'h0101] = 8'hC3;
    do_fetch("timeout_recover", 16'h0100, 2, 0);
  endtask

  task automatic test_flush();
    ack_delay = 0;
    pc = 16'h0010; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_ack !== 1'b1 || mem_addr !== 16'h0011) begin
      n_bad++; $display("FAIL flush_setup: got req=%b ack=%b addr=%h want 1 1 0011", mem_req, mem_ack, mem_addr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_hi: got req=%b v=%b busy=%b want 0 0 0", mem_req, inst_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_no_valid: got %b want 0", inst_valid);
      end
    end
    mem[16'h0004] = 8'h01; mem[16'h0005] = 8'h56;
    do_fetch("flush_recover", 16'h0004, 0, 0);
    n_cmp++;
    if (inst !== 16'h5601) begin
      n_bad++; $display("FAIL flush_recover_const: got %h want 5601", inst);
    end
    // flush while an instruction is held
    pc = 16'h0020; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_hold_setup: got %b want 1", inst_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_hold: got v=%b busy=%b want 0 0", inst_valid, busy);
    end
    // flush in IDLE beats a same-cycle pc_valid
    pc_valid = 1'b1; flush = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle: got busy=%b req=%b want 0 0", busy, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 3;
    pc = 16'h0030; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin
      n_bad++; $display("FAIL rst_mid_setup: got req=%b addr=%h want 1 0030", mem_req, mem_addr);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, inst_valid, pc_ready, busy, timeout} !== 5'b0 || mem_addr !== 16'h0 || inst !== 16'h0) begin
      n_bad++; $display("FAIL rst_mid: got req=%b v=%b rdy=%b busy=%b tmo=%b addr=%h inst=%h want zeros",
                        mem_req, inst_valid, pc_ready, busy, timeout, mem_addr, inst);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    mem[16'h0002] = 8'h58; mem[16'h0003] = 8'h0A;
    do_fetch("rst_recover", 16'h0002, 0, 0);
    n_cmp++;
    if (inst !== 16'h0A58) begin
      n_bad++; $display("FAIL rst_recover_const: got %h want 0a58", inst);
    end
  endtask

  task automatic test_random();
    logic [15:0] pcv;
    for (int i = 0; i < 20; i++) begin
      pcv = 16'($urandom);
      mem[pcv] = 8'($urandom);
      mem[pcv + 16'd1] = 8'($urandom);
      do_fetch("random", pcv, $urandom_range(0, 4), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    do_fetch("b2b_a", 16'h1234, 0, 0);
    do_fetch("b2b_b", 16'h1236, 0, 0);
    do_fetch("b2b_c", 16'h1237, 5, 0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_zero_wait();
    test_stall();
    test_wrap();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
